// File: rtl/stream_fifo.sv
// Multi-entry valid/ready stream FIFO with tlast framing, occupancy, almost-full and synchronous flush.
// Every output is a register; no input reaches an output combinationally.
module stream_fifo #(
  parameter int BITS        = 32,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1,
  parameter int LEVEL_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               recv_tvalid,
  output logic               recv_tready,
  input  logic [BITS-1:0]    recv_tdata,
  input  logic               recv_tlast,
  output logic               send_tvalid,
  input  logic               send_tready,
  output logic [BITS-1:0]    send_tdata,
  output logic               send_tlast,
  output logic [LEVEL_W-1:0] level,
  output logic               almost_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BITS:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [BITS:0]        head_q, head_d;
  logic                 rdy_q, rdy_d;
  logic                 vld_q, vld_d;
  logic                 af_q, af_d;
  logic                 push, pop;

  assign push = recv_tvalid & rdy_q;
  assign pop  = vld_q & send_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
      // The head register mirrors mem[rd_ptr]; incoming word bypasses when it becomes the head.
      if (push && ((level_q == '0) || (pop && (level_q == LEVEL_W'(1)))))
        head_d = {recv_tlast, recv_tdata};
      else if (pop && (level_q > LEVEL_W'(1)))
        head_d = mem_q[rd_ptr_d];
    end
    vld_d = (level_d != '0);
    rdy_d = (level_d < LEVEL_W'(DEPTH));
    af_d  = (level_d >= LEVEL_W'(ALMOST_FULL));
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {recv_tlast, recv_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      af_q     <= af_d;
    end
  end

  assign recv_tready = rdy_q;
  assign send_tvalid = vld_q;
  assign send_tdata  = head_q[BITS-1:0];
  assign send_tlast  = head_q[BITS];
  assign level       = level_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: fill/drain vector table, scoreboard model, and
// hand-written streaming, wrap, flush and async-reset sequences.
module tb_stream_fifo;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int LW    = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            recv_tvalid = 1'b0;
  logic            recv_tlast = 1'b0;
  logic [BITS-1:0] recv_tdata = '0;
  logic            send_tready = 1'b0;
  logic            recv_tready;
  logic            send_tvalid;
  logic            send_tlast;
  logic [BITS-1:0] send_tdata;
  logic [LW-1:0]   level;
  logic            almost_full;

  stream_fifo #(.BITS(BITS), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .recv_tvalid(recv_tvalid), .recv_tready(recv_tready),
    .recv_tdata(recv_tdata), .recv_tlast(recv_tlast),
    .send_tvalid(send_tvalid), .send_tready(send_tready),
    .send_tdata(send_tdata), .send_tlast(send_tlast),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model: words pushed when the model says ready, popped in order.
  logic [BITS:0] q[$];
  logic          rdy_m = 1'b0;
  logic          af_m = 1'b0;
  logic [BITS:0] head_m = '0;
  bit            chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      rdy_m  <= 1'b0;
      af_m   <= 1'b0;
      head_m <= '0;
    end else if (flush) begin
      q.delete();
      rdy_m <= 1'b1;
      af_m  <= 1'b0;
    end else begin
      if (q.size() > 0 && send_tready) begin
        chk("sb_pop_word", 64'({send_tlast, send_tdata}), 64'(q[0]));
        void'(q.pop_front());
      end
      if (recv_tvalid && rdy_m) q.push_back({recv_tlast, recv_tdata});
      rdy_m <= (q.size() < DEPTH);
      af_m  <= (q.size() >= AF);
      if (q.size() > 0) head_m <= q[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("sb_level", 64'(level), 64'(q.size()));
      chk("sb_send_tvalid", 64'(send_tvalid), 64'(q.size() > 0));
      chk("sb_recv_tready", 64'(recv_tready), 64'(rdy_m));
      chk("sb_almost_full", 64'(almost_full), 64'(af_m));
      chk("sb_head", 64'({send_tlast, send_tdata}), 64'(head_m));
    end
  end

  typedef struct {
    logic            v;
    logic [BITS-1:0] d;
    logic            l;
    logic            tr;
    logic [LW-1:0]   lvl;
    logic            rdy;
    logic            sv;
    logic [BITS-1:0] sd;
    logic            af;
  } vec_t;

  vec_t vt[11];

  initial begin
    int pushed, popped, cyc;
    logic [BITS-1:0] nxt;
    logic acc, pacc;

    vt[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h11, 1'b0};
    vt[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h11, 1'b0};
    vt[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h11, 1'b1};
    vt[3]  = '{1'b1, 32'h44, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h11, 1'b1};
    vt[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h11, 1'b1};
    vt[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h22, 1'b1};
    vt[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h22, 1'b1};
    vt[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h33, 1'b0};
    vt[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h44, 1'b0};
    vt[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h44, 1'b0};
    vt[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h44, 1'b0};

    void'($urandom(32'd2024));

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_recv_tready", 64'(recv_tready), 64'd0);
    chk("rst_send_tvalid", 64'(send_tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_send_tdata", 64'(send_tdata), 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk_en = 1'b1;
    step;
    chk("post_rst_ready", 64'(recv_tready), 64'd1);

    // Fill then drain with backpressure
    for (int i = 0; i < 11; i++) begin
      recv_tvalid = vt[i].v;
      recv_tdata  = vt[i].d;
      recv_tlast  = vt[i].l;
      send_tready = vt[i].tr;
      step;
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].lvl));
      chk($sformatf("vec%0d_ready", i), 64'(recv_tready), 64'(vt[i].rdy));
      chk($sformatf("vec%0d_svalid", i), 64'(send_tvalid), 64'(vt[i].sv));
      chk($sformatf("vec%0d_sdata", i), 64'(send_tdata), 64'(vt[i].sd));
      chk($sformatf("vec%0d_afull", i), 64'(almost_full), 64'(vt[i].af));
    end
    recv_tvalid = 1'b0;
    send_tready = 1'b0;

    // Streaming at one word per cycle
    recv_tvalid = 1'b1;
    send_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      recv_tdata = 32'(i + 1);
      recv_tlast = ((i + 1) % 5 == 0);
      step;
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_data", 64'(send_tdata), 64'(i + 1));
      chk("stream_last", 64'(send_tlast), 64'((i + 1) % 5 == 0));
    end
    recv_tvalid = 1'b0;
    recv_tlast  = 1'b0;
    step;
    chk("stream_drained", 64'(level), 64'd0);
    send_tready = 1'b0;

    // Wrap-around with random stalls
    pushed = 0;
    popped = 0;
    cyc = 0;
    nxt = 32'h100;
    while ((pushed < 3 * DEPTH || popped < 3 * DEPTH) && cyc < 400) begin
      if (!recv_tvalid && pushed < 3 * DEPTH && $urandom_range(0, 3) != 0) begin
        recv_tvalid = 1'b1;
        recv_tdata  = nxt;
        recv_tlast  = (nxt[1:0] == 2'b11);
      end
      send_tready = ($urandom_range(0, 2) != 0);
      acc  = recv_tvalid && recv_tready;
      pacc = send_tvalid && send_tready;
      step;
      cyc++;
      if (acc) begin
        pushed++;
        nxt = nxt + 1;
        recv_tvalid = 1'b0;
      end
      if (pacc) popped++;
      chk("wrap_level_range", 64'(level <= DEPTH), 64'd1);
    end
    chk("wrap_pushed", 64'(pushed), 64'(3 * DEPTH));
    chk("wrap_popped", 64'(popped), 64'(3 * DEPTH));
    recv_tvalid = 1'b0;
    recv_tlast  = 1'b0;
    send_tready = 1'b0;
    step;

    // Flush with coincident push and pop
    for (int i = 0; i < 3; i++) begin
      recv_tvalid = 1'b1;
      recv_tdata  = 32'hA1 + 32'(i);
      step;
    end
    chk("flush_pre_level", 64'(level), 64'd3);
    flush = 1'b1;
    recv_tdata  = 32'hAA;
    send_tready = 1'b1;
    step;
    flush = 1'b0;
    recv_tvalid = 1'b0;
    send_tready = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_svalid", 64'(send_tvalid), 64'd0);
    chk("flush_ready", 64'(recv_tready), 64'd1);
    chk("flush_hold_data", 64'(send_tdata), 64'hA1);
    recv_tvalid = 1'b1;
    recv_tdata  = 32'hBB;
    step;
    recv_tvalid = 1'b0;
    chk("flush_bb_valid", 64'(send_tvalid), 64'd1);
    chk("flush_bb_data", 64'(send_tdata), 64'hBB);
    chk("flush_bb_level", 64'(level), 64'd1);
    send_tready = 1'b1;
    step;
    send_tready = 1'b0;
    chk("flush_bb_drained", 64'(level), 64'd0);

    // Asynchronous reset between edges at level 2
    recv_tvalid = 1'b1;
    recv_tdata  = 32'hC1;
    step;
    recv_tdata  = 32'hC2;
    step;
    recv_tvalid = 1'b0;
    chk("areset_pre_level", 64'(level), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("areset_svalid", 64'(send_tvalid), 64'd0);
    chk("areset_ready", 64'(recv_tready), 64'd0);
    chk("areset_level", 64'(level), 64'd0);
    chk("areset_data", 64'(send_tdata), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step;
    chk("areset_resume_ready", 64'(recv_tready), 64'd1);
    chk("areset_resume_empty", 64'(send_tvalid), 64'd0);
    recv_tvalid = 1'b1;
    recv_tdata  = 32'hD1;
    send_tready = 1'b1;
    step;
    recv_tvalid = 1'b0;
    chk("areset_d1_data", 64'(send_tdata), 64'hD1);
    chk("areset_d1_level", 64'(level), 64'd1);
    step;
    chk("areset_d1_drained", 64'(level), 64'd0);
    send_tready = 1'b0;
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parametrised, multi-entry successor to the single-entry stream skid buffer. It buffers up to DEPTH words of a valid/ready stream with packet framing (tlast), reports occupancy and an almost-full threshold, and supports a synchronous flush. The block sits between stream producers and consumers wherever a single skid entry cannot absorb burst or backpressure latency, for example between the PDM decimators and the packetiser. All outputs are registered, so there is no combinational path from any input to any output.

Parameters:
BITS, 32, payload width of tdata.
DEPTH, 4, number of storage entries; power of two, at least 2.
ALMOST_FULL, DEPTH-1, almost_full asserts when level >= ALMOST_FULL; legal range is 1..DEPTH.
LEVEL_W, $clog2(DEPTH+1), width of level (derived; do not override).

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous flush; discards all stored words.
recv_tvalid  input  1  upstream word valid.
recv_tready  output  1  block can accept a word.
recv_tdata  input  BITS  upstream payload.
recv_tlast  input  1  upstream end-of-packet marker.
send_tvalid  output  1  head word valid.
send_tready  input  1  downstream accepts the head word.
send_tdata  output  BITS  head payload.
send_tlast  output  1  head end-of-packet marker.
level  output  LEVEL_W  number of stored words, 0..DEPTH.
almost_full  output  1  level >= ALMOST_FULL.

Behaviour:
- Reset is asynchronous and active-high; one clock. While rst is high: recv_tready=0, send_tvalid=0, send_tdata=0, send_tlast=0, level=0, almost_full=0, and all pointers are 0.
- First rising edge after rst deasserts: recv_tready goes to 1. Inputs are ignored until then.
- Push: recv_tvalid && recv_tready at an edge stores {tlast, tdata}.
- Pop: send_tvalid && send_tready at an edge removes the head word.
- recv_tready = (level < DEPTH), registered from next-state level. It does not depend on send_tready.
  - When full, a pop frees a slot, but recv_tready rises only on the following cycle. A push and a pop in the same cycle at full is impossible.
- Latency: a word pushed into an empty FIFO is presented on send_* at the next edge (1 cycle).
- Ordering: strict FIFO; tlast travels with its word.
- Handshake guarantees:
  - send_tvalid is asserted iff level > 0.
  - While send_tvalid && !send_tready, send_tvalid, send_tdata and send_tlast hold stable.
  - send_tdata and send_tlast change only when a new head word is loaded; otherwise they hold their last value, including when the FIFO goes empty.
- Simultaneous push and pop (0 < level < DEPTH): level is unchanged, and order is preserved.
- Simultaneous push and pop at level == 1: the head advances to the new word with no bubble, so send_tvalid stays 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- level updates at the same edge as the push or pop. almost_full = (next level >= ALMOST_FULL), registered.
- flush=1 at an edge:
  - level=0, send_tvalid=0, and pointers reset.
  - Any push or pop in the same cycle is discarded; flush has priority.
  - recv_tready=1 on the next cycle.
  - send_tdata and send_tlast hold their values.
- Reset mid-transfer: all stored words are lost and outputs drop immediately (asynchronously) to their reset values. The upstream may not assert recv_tvalid in the cycle after reset.
- Upstream contract: once recv_tvalid=1 with recv_tready=0, the producer holds recv_tvalid, recv_tdata and recv_tlast stable until accepted.
- Formal: the existing handshake properties apply unchanged on both sides. Add the following:
  - level never exceeds DEPTH.
  - level equals pushes minus pops since the last reset or flush.
  - A tracked arbitrary word emerges intact and in order.

Test Plan:
- Reset then fill: rst held 3 cycles, then push 0x11,0x22,0x33,0x44 (DEPTH=4) with send_tready=0 → level 1,2,3,4; almost_full rises with level=3; recv_tready=0 at level 4; send_tdata=0x11, stable throughout.
- Drain with backpressure: from full, toggle send_tready 1,0,1,1,0,1 → outputs 0x11,0x22,0x33,0x44 in order, each held while stalled; recv_tready=1 one cycle after the first pop; send_tvalid=0 after the fourth pop.
- Streaming: continuous recv_tvalid=1 and send_tready=1 with an incrementing payload, tlast every 5th word → one word per cycle after 1-cycle latency; level stays 1; tlast appears on words 5, 10, 15, …
- Wrap-around: 3 × DEPTH pushes and pops with random stalls (seeded) → output sequence equals input sequence; level always 0..4.
- Flush: level=3, flush=1 coincident with push 0xAA and pop → next cycle level=0, send_tvalid=0, 0xAA not stored; the following push 0xBB appears at send with 1-cycle latency.
- Async reset mid-burst: assert rst between edges at level=2 → send_tvalid, recv_tready and level go to 0 before the next edge; after release, normal operation resumes with an empty FIFO.
